// File: rtl/pulse_record_fifo_pkg.sv
// Shared types for the pulse record path: FSM states, record layout and
// the helper that sizes a flattened record for a given counter width.
package pulse_pkg;

    localparam int PULSE_W = 24;

    typedef enum logic [2:0] {
        ST_START     = 3'd0,
        ST_WAIT_RISE = 3'd1,
        ST_CAP_M     = 3'd2,
        ST_WAIT_FALL = 3'd3,
        ST_CAP_P     = 3'd4
    } pulse_state_t;

    // Field order matches the flattened record carried through the FIFO.
    typedef struct packed {
        logic [PULSE_W-1:0] low;
        logic [PULSE_W-1:0] high;
        logic [PULSE_W:0]   period;
        logic               sat;
    } pulse_rec_t;

    // low + high + period (one bit wider) + sat flag
    function automatic int rec_width(input int w);
        return 3 * w + 2;
    endfunction

endpackage

// File: rtl/pulse_record_fifo_sync_fifo.sv
// Single-clock FIFO with a registered head word. The head register is
// refreshed on the same edge as the push/pop that changes it, so a write
// into an empty FIFO is visible on dout the following cycle. dout is zero
// whenever the FIFO is empty.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int REC_W = 74
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [REC_W-1:0]         din,
    output logic [REC_W-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   fill
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [REC_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [REC_W-1:0] head_q, head_d;
    logic             push_ok, pop_ok;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = head_q;
    assign fill    = cnt_q;

    // Pointer, occupancy and head-word next-state; clear wins over push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q + AW'(push_ok);
        rd_ptr_d = rd_ptr_q + AW'(pop_ok);
        cnt_d    = cnt_q + CW'(push_ok) - CW'(pop_ok);
        head_d   = head_q;
        if (cnt_d == '0) begin
            head_d = '0;
        end else if (cnt_q == '0 || (cnt_q == CW'(1) && pop_ok)) begin
            // The incoming word becomes the head directly.
            head_d = din;
        end else if (pop_ok) begin
            head_d = mem_q[rd_ptr_d];
        end
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            head_d   = '0;
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count.
    always_ff @(posedge clk) begin
        if (reset_n && !clear && push_ok) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/pulse_record_fifo.sv
// Captures completed low/high duration pairs from the pulse counter and
// queues them as {low, high, period, sat} records behind a valid/ready port.
// Handshake: a record transfers on every clock edge where out_valid and
// out_ready are both high; out_* fields hold steady while out_valid is high
// and out_ready is low.
module pulse_record_fifo
    import pulse_pkg::*;
#(
    parameter int W     = PULSE_W,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     trigger,
    input  logic [W-1:0]             count_p,
    input  logic [W-1:0]             count_m,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_low,
    output logic [W-1:0]             out_high,
    output logic [W:0]               out_period,
    output logic                     out_sat,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic [7:0]               drop_cnt,
    output pulse_state_t             dbg_state
);

    localparam int REC_W = rec_width(W);

    logic [2:0]       sync_q, sync_d;
    pulse_state_t     state_q, state_d;
    logic [W-1:0]     m_hold_q, m_hold_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       drop_q, drop_d;
    logic             rise, fall, push, pop, drop;
    logic             fifo_full, fifo_empty;
    logic [W:0]       period;
    logic [REC_W-1:0] push_rec, head_rec;

    // The edge-detect cycle lines up with the pulse counter's update cycle.
    assign rise = (sync_q[2:1] == 2'b01);
    assign fall = (sync_q[2:1] == 2'b10);

    // Trigger shift register; clear does not disturb it.
    always_comb begin
        sync_d = {sync_q[1:0], trigger};
    end

    // Capture sequencer: skip the first partial low interval, then pair
    // each low duration with the following high duration.
    always_comb begin
        state_d  = state_q;
        m_hold_d = m_hold_q;
        push     = 1'b0;
        case (state_q)
            ST_START:     if (fall) state_d = ST_WAIT_RISE;
            ST_WAIT_RISE: begin
                if (rise)      state_d = ST_CAP_M;
                else if (fall) state_d = ST_START;   // lost a rise
            end
            ST_CAP_M: begin
                m_hold_d = count_m;
                state_d  = ST_WAIT_FALL;
            end
            ST_WAIT_FALL: begin
                if (fall)      state_d = ST_CAP_P;
                else if (rise) state_d = ST_START;   // lost a fall
            end
            ST_CAP_P: begin
                push    = 1'b1;
                state_d = ST_WAIT_RISE;
            end
            default:      state_d = ST_START;
        endcase
        if (clear) begin
            state_d  = ST_START;
            m_hold_d = '0;
            push     = 1'b0;
        end
    end

    // Record assembly; the period keeps the carry bit.
    always_comb begin
        period   = {1'b0, m_hold_q} + {1'b0, count_p};
        push_rec = {m_hold_q, count_p, period, (&m_hold_q) | (&count_p)};
    end

    assign pop  = out_ready && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    // Drop bookkeeping: sticky flag and a saturating counter.
    always_comb begin
        ovf_d  = ovf_q | drop;
        drop_d = drop_q;
        if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
        if (clear) begin
            ovf_d  = 1'b0;
            drop_d = '0;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_q   <= '0;
            state_q  <= ST_START;
            m_hold_q <= '0;
            ovf_q    <= 1'b0;
            drop_q   <= '0;
        end else begin
            sync_q   <= sync_d;
            state_q  <= state_d;
            m_hold_q <= m_hold_d;
            ovf_q    <= ovf_d;
            drop_q   <= drop_d;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .REC_W (REC_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .din     (push_rec),
        .dout    (head_rec),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .fill    (fill)
    );

    assign {out_low, out_high, out_period, out_sat} = head_rec;
    assign out_valid = !fifo_empty;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pulse_record_fifo.sv
// Bench for pulse_record_fifo: directed sequences, a vector table and a
// randomized run, all checked every cycle against a record-level model.
module tb_pulse_record_fifo;
    import pulse_pkg::*;

    localparam int W     = 24;
    localparam int DEPTH = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset_n, trigger, clear, out_ready;
    logic [W-1:0]       count_p, count_m;
    logic               out_valid, out_sat, overflow;
    logic [W-1:0]       out_low, out_high;
    logic [W:0]         out_period;
    logic [3:0]         fill;
    logic [7:0]         drop_cnt;
    pulse_state_t       dbg_state;

    pulse_record_fifo #(.W(W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trigger    (trigger),
        .count_p    (count_p),
        .count_m    (count_m),
        .clear      (clear),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_low    (out_low),
        .out_high   (out_high),
        .out_period (out_period),
        .out_sat    (out_sat),
        .fill       (fill),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .dbg_state  (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    typedef struct packed {
        logic [W-1:0] low;
        logic [W-1:0] high;
        logic [W:0]   period;
        logic         sat;
    } rec_t;

    rec_t         exp_q[$];      // records expected in the FIFO, head first
    rec_t         pend_rec[$];   // records formed but not yet written
    int           pend_edge[$];  // clock edge at which each is written
    int           n_chk = 0, n_fail = 0, cyc = 0, m_drop = 0;
    bit           m_ovf, armed, have_low, lost_mode, rand_rdy;
    logic         prev_trig;
    logic [W-1:0] m_low;

    function automatic rec_t mk(input logic [W-1:0] lo, input logic [W-1:0] hi);
        rec_t r;
        r.low    = lo;
        r.high   = hi;
        r.period = {1'b0, lo} + {1'b0, hi};
        r.sat    = (lo == {W{1'b1}}) || (hi == {W{1'b1}});
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Model update for one clock edge, using the inputs sampled at that edge.
    // A record is written 3 edges after the edge that first samples the
    // trigger fall (detect latency 2, then one capture cycle).
    task automatic model_edge();
        int sz;
        bit pop, push;
        rec_t r;
        if (!reset_n || clear) begin
            exp_q.delete(); pend_rec.delete(); pend_edge.delete();
            m_drop = 0; m_ovf = 0; armed = 0; have_low = 0;
            prev_trig = reset_n ? trigger : 1'b0;
            return;
        end
        sz   = exp_q.size();
        pop  = (sz > 0) && out_ready;
        push = (pend_edge.size() > 0) && (pend_edge[0] == cyc);
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            r = pend_rec.pop_front();
            void'(pend_edge.pop_front());
            if (sz < DEPTH || pop) exp_q.push_back(r);
            else begin
                m_drop++;
                m_ovf = 1;
            end
        end
        if (!lost_mode) begin
            if (trigger && !prev_trig) begin
                if (armed) begin
                    have_low = 1;
                    m_low    = count_m;
                end
            end else if (!trigger && prev_trig) begin
                if (armed && have_low) begin
                    pend_rec.push_back(mk(m_low, count_p));
                    pend_edge.push_back(cyc + 3);
                end
                armed    = 1;
                have_low = 0;
            end
        end
        prev_trig = trigger;
    endtask

    task automatic model_check();
        chk("valid", out_valid, exp_q.size() > 0);
        chk("fill", fill, exp_q.size());
        chk("overflow", overflow, m_ovf);
        chk("drop_cnt", drop_cnt, (m_drop > 255) ? 255 : m_drop);
        if (exp_q.size() > 0) begin
            chk("head_low", out_low, exp_q[0].low);
            chk("head_high", out_high, exp_q[0].high);
            chk("head_period", out_period, exp_q[0].period);
            chk("head_sat", out_sat, exp_q[0].sat);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        model_check();
    endtask

    // Hold trigger at lvl for n cycles; the counter output that updates on
    // this edge (count_m on a rise, count_p on a fall) takes val.
    task automatic drive_level(input logic lvl, input int n, input logic [W-1:0] val);
        trigger = lvl;
        if (lvl) count_m = val;
        else     count_p = val;
        repeat (n) tick();
    endtask

    task automatic pulse(input int hi, input int lo, input logic [W-1:0] mv, input logic [W-1:0] pv);
        drive_level(1'b1, hi, mv);
        drive_level(1'b0, lo, pv);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    // From a low trigger: one full pulse whose fall arms the capture.
    task automatic arm();
        drive_level(1'b1, 4, '0);
        drive_level(1'b0, 4, '0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        int           hi;
        int           lo;
        logic [W-1:0] m;
        logic [W-1:0] p;
        logic [W-1:0] exp_low;
        logic [W-1:0] exp_high;
        logic [W:0]   exp_period;
        logic         exp_sat;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{3, 4, 24'h000001, 24'hFFFFFF, 24'h000001, 24'hFFFFFF, 25'h1000000, 1'b1};
        tbl[1] = '{5, 3, 24'd30,     24'd5,      24'd30,     24'd5,      25'd35,       1'b0};
        tbl[2] = '{4, 5, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 25'h1FFFFFE, 1'b1};
        tbl[3] = '{3, 3, 24'h000000, 24'h000000, 24'h000000, 24'h000000, 25'h0000000, 1'b0};
        tbl[4] = '{6, 4, 24'h123456, 24'h654321, 24'h123456, 24'h654321, 25'h0777777, 1'b0};
        tbl[5] = '{3, 6, 24'hFFFFFE, 24'h000002, 24'hFFFFFE, 24'h000002, 25'h1000000, 1'b0};

        reset_n = 1'b0; trigger = 1'b0; clear = 1'b0; out_ready = 1'b0;
        count_m = '0; count_p = '0; rand_rdy = 0; lost_mode = 0;
        prev_trig = 1'b0;

        // Reset state.
        repeat (2) tick();
        reset_n = 1'b1;
        chk("rst_state", dbg_state, ST_START);
        chk("rst_low", out_low, 0);
        chk("rst_period", out_period, 0);
        chk("rst_sat", out_sat, 0);

        // First record discarded; second is {30,5,35} two cycles after fall detect.
        drive_level(1'b0, 10, 24'd0);
        drive_level(1'b1, 20, 24'd10);
        drive_level(1'b0, 30, 24'd20);
        drive_level(1'b1, 5,  24'd30);
        trigger = 1'b0; count_p = 24'd5;
        tick(); chk("lat_e0", out_valid, 0);
        tick(); chk("lat_e1", out_valid, 0);
        tick(); chk("lat_e2", out_valid, 0);
        tick(); chk("lat_e3", out_valid, 1);
        chk("first_fill", fill, 1);
        chk("first_low", out_low, 30);
        chk("first_high", out_high, 5);
        chk("first_period", out_period, 35);
        repeat (2) tick();
        chk("stable_low", out_low, 30);
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("first_popped", fill, 0);

        // Table vectors, queued then drained in order.
        do_clear();
        arm();
        for (int i = 0; i < 6; i++) pulse(tbl[i].hi, tbl[i].lo, tbl[i].m, tbl[i].p);
        repeat (4) tick();
        chk("tbl_fill", fill, 6);
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            chk("tbl_low", out_low, tbl[i].exp_low);
            chk("tbl_high", out_high, tbl[i].exp_high);
            chk("tbl_period", out_period, tbl[i].exp_period);
            chk("tbl_sat", out_sat, tbl[i].exp_sat);
            tick();
        end
        out_ready = 1'b0;
        chk("tbl_empty", out_valid, 0);

        // Overflow: 10 pulses into 8 entries with no reader.
        do_clear();
        arm();
        for (int i = 0; i < 10; i++) pulse(3 + i % 3, 4, 24'(100 + i), 24'(200 + i));
        chk("ovf_fill", fill, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_drops", drop_cnt, 2);

        // Full FIFO with a pop on the write edge: accepted, no drop.
        trigger = 1'b1; count_m = 24'd500;
        repeat (4) tick();
        trigger = 1'b0; count_p = 24'd600;
        repeat (3) tick();
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        chk("fullpop_fill", fill, 8);
        chk("fullpop_drops", drop_cnt, 2);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_low", out_low, (i < 7) ? 101 + i : 500);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty", fill, 0);

        // Lost fall: a one-cycle low glitch right after a rise.
        do_clear();
        arm();
        lost_mode = 1;
        trigger = 1'b1; count_m = 24'd7; tick();
        trigger = 1'b0; tick();
        trigger = 1'b1; repeat (6) tick();
        lost_mode = 0; armed = 0; have_low = 0;
        chk("lost_state", dbg_state, ST_START);
        chk("lost_nopush", fill, 0);
        drive_level(1'b0, 4, 24'd9);
        drive_level(1'b1, 4, 24'd11);
        chk("lost_rearm", fill, 0);
        drive_level(1'b0, 5, 24'd13);
        chk("lost_fill", fill, 1);
        chk("lost_low", out_low, 11);
        chk("lost_high", out_high, 13);

        // Clear mid-stream with 3 queued.
        do_clear();
        arm();
        for (int i = 0; i < 3; i++) pulse(3, 4, 24'(i + 1), 24'(i + 2));
        chk("pre_clear_fill", fill, 3);
        do_clear();
        chk("clr_fill", fill, 0);
        chk("clr_valid", out_valid, 0);
        chk("clr_drops", drop_cnt, 0);
        chk("clr_state", dbg_state, ST_START);

        // Reset mid-stream after drops.
        arm();
        for (int i = 0; i < 10; i++) pulse(3, 4, 24'(i + 1), 24'(i + 2));
        chk("pre_rst_drops", drop_cnt, 2);
        reset_n = 1'b0; tick(); reset_n = 1'b1;
        chk("rst2_fill", fill, 0);
        chk("rst2_valid", out_valid, 0);
        chk("rst2_drops", drop_cnt, 0);
        chk("rst2_ovf", overflow, 0);
        chk("rst2_state", dbg_state, ST_START);

        // Randomized pulses with a random reader.
        do_clear();
        arm();
        rand_rdy = 1;
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] mv, pv;
            mv = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
            pv = ($urandom_range(0, 7) == 0) ? {W{1'b1}} : W'($urandom);
            pulse($urandom_range(3, 10), $urandom_range(3, 10), mv, pv);
        end
        rand_rdy = 0;
        out_ready = 1'b1;
        repeat (12) tick();
        chk("rand_drained", fill, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
